// File: rtl/bin_to_disp_enc.sv
// Signed binary to display-symbol encoder: serial double-dabble, then one formatting cycle
// that applies leading-blank suppression, sign placement and an "Err" overflow pattern.
module bin_to_disp_enc #(
  parameter int WIDTH      = 12,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [5*NUM_DIGITS-1:0] disp
);

  // Handshake: start is accepted on any rising edge where the FSM is IDLE; while busy it is
  // ignored. done is a one-cycle pulse marking the edge at which disp/err were updated.

  localparam int BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int N_W   = $clog2(NUM_DIGITS + 3);

  localparam logic [4:0] SYM_E     = 5'd14;
  localparam logic [4:0] SYM_R     = 5'd20;
  localparam logic [4:0] SYM_NEG   = 5'd22;
  localparam logic [4:0] SYM_BLANK = 5'd23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_neg;
  logic [WIDTH-1:0]        r_mag;
  logic [BCD_W-1:0]        r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_done;
  logic                    r_err;
  logic [5*NUM_DIGITS-1:0] r_disp;

  logic [WIDTH-1:0]        w_mag_in;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W-1:0]        w_bcd_sh;
  logic [WIDTH-1:0]        w_mag_sh;
  logic [N_W-1:0]          w_n;
  logic [N_W-1:0]          w_need;
  logic                    w_ovf;
  logic [5*NUM_DIGITS-1:0] w_disp_fmt;

  // Most negative input wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude wanted.
  assign w_mag_in = value[WIDTH-1] ? ({WIDTH{1'b0}} - value) : value;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d <= NUM_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_sh = {w_bcd_adj[BCD_W-2:0], r_mag[WIDTH-1]};
  assign w_mag_sh = {r_mag[WIDTH-2:0], 1'b0};

  always_comb begin
    w_n = N_W'(1);
    for (int d = 0; d <= NUM_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] != 4'd0) begin
        w_n = N_W'(d + 1);
      end
    end
    w_need = w_n + {{(N_W-1){1'b0}}, r_neg};
    w_ovf  = (w_need > N_W'(NUM_DIGITS));
  end

  always_comb begin
    w_disp_fmt = {NUM_DIGITS{SYM_BLANK}};
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (w_ovf) begin
        if (p == 0 || p == 1) begin
          w_disp_fmt[5*p +: 5] = SYM_R;
        end else if (p == 2) begin
          w_disp_fmt[5*p +: 5] = SYM_E;
        end
      end else if (N_W'(p) < w_n) begin
        w_disp_fmt[5*p +: 5] = {1'b0, r_bcd[4*p +: 4]};
      end else if (N_W'(p) == w_n && r_neg) begin
        w_disp_fmt[5*p +: 5] = SYM_NEG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_next_state = FORMAT;
      FORMAT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg  <= 1'b0;
      r_mag  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_disp <= {NUM_DIGITS{SYM_BLANK}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_neg <= value[WIDTH-1];
            r_mag <= w_mag_in;
            r_bcd <= '0;
            r_cnt <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_sh;
          r_mag <= w_mag_sh;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FORMAT: begin
          r_disp <= w_disp_fmt;
          r_err  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign err  = r_err;
  assign disp = r_disp;

endmodule

// File: tb/tb_bin_to_disp_enc.sv
// Scoreboard bench for bin_to_disp_enc: directed vectors push expected {err,disp} and done
// cycle; a negedge monitor pops and compares whenever done is seen.
module tb_bin_to_disp_enc;

  localparam int WIDTH = 12;
  localparam int ND    = 4;
  localparam int W     = 5 * ND + 1;
  localparam int LAT   = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             err;
  logic [5*ND-1:0]  disp;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           cyc;
  int           checks;
  int           fails;

  bin_to_disp_enc #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .err(err), .disp(disp)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mk(input logic e, input int d3, input int d2,
                                      input int d1, input int d0);
    logic [4:0] s3, s2, s1, s0;
    s3 = 5'(d3); s2 = 5'(d2); s1 = 5'(d1); s0 = 5'(d0);
    return {e, s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  // monitor: compares every done pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        logic [W-1:0] e;
        int           l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result", int'({err, disp}), int'(e));
        check("latency", cyc, l);
      end
    end
  end

  // driver: start is sampled at the next edge, which becomes edge number cyc+1
  task automatic issue(input int v, input logic [W-1:0] e);
    start = 1'b1;
    value = WIDTH'(v);
    exp_q.push_back(e);
    lat_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    value = WIDTH'($urandom_range(0, 4095));
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int v, input logic [W-1:0] e);
    issue(v, e);
    drain();
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    value  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_disp", int'(disp), int'(mk(1'b0, 23, 23, 23, 23) & 21'h0FFFFF));

    issue(0, mk(1'b0, 23, 23, 23, 0));
    check("busy_after_start", int'(busy), 1);
    drain();

    run(2047, mk(1'b0, 2, 0, 4, 7));
    run(7,    mk(1'b0, 23, 23, 23, 7));
    run(100,  mk(1'b0, 23, 1, 0, 0));
    run(-42,  mk(1'b0, 23, 22, 4, 2));
    run(-999, mk(1'b0, 22, 9, 9, 9));
    run(-1,   mk(1'b0, 23, 23, 22, 1));
    run(-2048, mk(1'b1, 23, 14, 20, 20));
    run(5,    mk(1'b0, 23, 23, 23, 5));

    // starts while busy are dropped; a start in the done cycle is accepted
    issue(1234, mk(1'b0, 1, 2, 3, 4));
    for (int j = 1; j <= LAT; j++) begin
      start = (j == 3 || j == 12);
      value = WIDTH'(999);
      @(negedge clk);
    end
    check("done_cycle", int'(done), 1);
    issue(88, mk(1'b0, 23, 23, 8, 8));
    drain();

    // reset mid-conversion aborts with no done pulse
    start = 1'b1;
    value = WIDTH'(1500);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_err", int'(err), 0);
    check("abort_disp", int'(disp), int'(mk(1'b0, 23, 23, 23, 23) & 21'h0FFFFF));
    repeat (LAT + 2) @(negedge clk);
    run(9, mk(1'b0, 23, 23, 23, 9));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_disp_enc.md
Name: bin_to_disp_enc

Overview:
- Sequential encoder that turns a signed two's-complement binary value into NUM_DIGITS 5-bit display symbol codes.
- Each code feeds one per-digit seven-segment decoder.
- Implemented as iterative double-dabble (one bit per clock), then a one-cycle formatting pass.
- Formatting does leading-blank suppression, sign placement and an "Err" overflow pattern.
- Sits between datapath results and the display decoders.

Parameters:
- WIDTH, 12, input value width (signed); constraint WIDTH <= 3*NUM_DIGITS+3
- NUM_DIGITS, 4, display positions; constraint NUM_DIGITS >= 3

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request conversion of value; sampled only in IDLE
- value  input  WIDTH  signed two's-complement operand, sampled on accepted start
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; disp/err valid and updated this cycle
- err  output  1  last result did not fit; held until next done or reset
- disp  output  5*NUM_DIGITS  symbol codes; position 0 (rightmost) in bits [4:0], position i in [5i+4:5i]

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Symbol encoding:
  - 0-15: hex digits 0-F
  - 16 G, 17 L, 18 N, 19 O, 20 R, 21 T
  - 22 NEG (minus sign), 23 BLANK
  - All other codes unused.
- Reset: state IDLE; busy=0, done=0, err=0; every disp position = BLANK (23).
- States: IDLE, SHIFT, FORMAT.
- IDLE:
  - start=1 at edge k latches neg=value[WIDTH-1] and mag=|value| as a WIDTH-bit unsigned (most negative value gives 2^(WIDTH-1)).
  - Clears the BCD accumulator (NUM_DIGITS+1 BCD digits), loads bit counter = WIDTH, sets busy=1, goes to SHIFT.
- SHIFT:
  - Per edge: add 3 to every BCD digit >= 5, then shift {bcd, mag} left by 1 and decrement the counter.
  - After WIDTH edges, go to FORMAT.
- FORMAT (one edge): compute n = index of most significant nonzero BCD digit + 1 (n = 1 for zero); need = n + neg.
  - If need > NUM_DIGITS: positions 2,1,0 = E(14), R(20), R(20); higher positions BLANK; err=1.
  - Otherwise:
    - positions < n get their BCD digits;
    - position n gets NEG if neg, else BLANK (only if n < NUM_DIGITS);
    - positions above get BLANK;
    - err=0.
  - At the same edge: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge k gives done high after edge k+WIDTH+1 (13 cycles at default). busy is high after edges k through k+WIDTH.
- start while busy: ignored, not queued.
- start during the done cycle: accepted, since state is IDLE. disp/err keep the just-written result until the next FORMAT.
- value changes after acceptance have no effect.
- disp and err change only at FORMAT or reset; they never show intermediate values.
- rst mid-conversion: abort immediately, return to reset values, no done pulse.
- Zero is never displayed with a sign.

Test Plan:
- Reset: assert rst 2 cycles -> busy=0, done=0, err=0, disp = {23,23,23,23}. Then start with value=0 -> done exactly 13 cycles after the start edge; disp = {23,23,23,0}; err=0.
- value=2047 -> disp {2,0,4,7}, err=0. Then value=7 -> {23,23,23,7}. Then value=100 -> {23,1,0,0} (interior zeros kept).
- value=-42 -> {23,22,4,2}. value=-999 -> {22,9,9,9}, err=0. value=-1 -> {23,23,22,1}.
- Overflow: value=-2048 (0x800) -> {23,14,20,20}, err=1. A following value=5 clears err to 0 -> {23,23,23,5}.
- Handshake: pulse start with 1234, re-pulse start with 999 at cycles 3 and 12 -> both ignored; a single done gives {1,2,3,4}. Assert start again during the done cycle with 88 -> accepted; next done 13 cycles later gives {23,23,8,8}.
- Reset mid-op: start 1500, assert rst at cycle 6 -> no done pulse, busy=0 next cycle, disp all 23. Next start 9 -> {23,23,23,9}.
